// File: rtl/sd_fill_writer_pkg.sv
// sd_fill_pkg: shared state encoding, register offsets and CTRL bit positions
// for the SDRAM fill writer.
package sd_fill_pkg;
    typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;
    localparam logic [3:0] OFF_DEST = 4'd0;
    localparam logic [3:0] OFF_LEN  = 4'd4;
    localparam logic [3:0] OFF_PAT  = 4'd6;
    localparam logic [3:0] OFF_CTRL = 4'd8;
    localparam int CTRL_START = 0;
    localparam int CTRL_INC   = 1;
    localparam int CTRL_ABORT = 2;
    localparam int BURST_WORDS_DEF = 8;
endpackage

// File: rtl/sd_fill_writer_regs.sv
// sd_fill_regs: byte-wide command register file with the cmd_write/cmd_done
// handshake; emits one-cycle start/abort strobes for the fill FSM.
module sd_fill_regs
    import sd_fill_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       cmd_address_i,
    input  logic [7:0]       cmd_byte_i,
    input  logic             cmd_write_i,
    input  logic             busy_i,
    output logic             cmd_done_o,
    output logic [31:0]      dest_o,
    output logic [LEN_W-1:0] len_o,
    output logic [15:0]      pat_o,
    output logic             inc_o,
    output logic             start_o,
    output logic             abort_o
);
    logic             cmd_done_q, start_q, abort_q, inc_q;
    logic [31:0]      dest_q;
    logic [LEN_W-1:0] len_q;
    logic [15:0]      pat_q;
    logic             wr, ctrl_wr;

    // A held cmd_write only performs its write on the first, unacknowledged cycle.
    assign wr      = cmd_write_i && !cmd_done_q;
    assign ctrl_wr = wr && cmd_address_i == OFF_CTRL;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_done_q <= 1'b0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            inc_q      <= 1'b0;
            dest_q     <= '0;
            len_q      <= '0;
            pat_q      <= '0;
        end else begin
            cmd_done_q <= cmd_write_i;
            start_q    <= ctrl_wr && cmd_byte_i[CTRL_START] && !busy_i;
            abort_q    <= ctrl_wr && cmd_byte_i[CTRL_ABORT];
            if (wr && !busy_i) begin
                if (cmd_address_i < OFF_LEN)
                    dest_q[{cmd_address_i[1:0], 3'b000} +: 8] <= cmd_byte_i;
                else if (cmd_address_i < OFF_PAT)
                    len_q[{cmd_address_i[0], 3'b000} +: 8] <= cmd_byte_i;
                else if (cmd_address_i < OFF_CTRL)
                    pat_q[{cmd_address_i[0], 3'b000} +: 8] <= cmd_byte_i;
                else if (cmd_address_i == OFF_CTRL)
                    inc_q <= cmd_byte_i[CTRL_INC];
            end
        end
    end

    assign cmd_done_o = cmd_done_q;
    assign dest_o     = dest_q;
    assign len_o      = len_q;
    assign pat_o      = pat_q;
    assign inc_o      = inc_q;
    assign start_o    = start_q;
    assign abort_o    = abort_q;
endmodule

// File: rtl/sd_fill_writer.sv
// sd_fill_writer: fills an SDRAM halfword region with a constant or incrementing
// pattern through the shared sd_* burst port, 8-word bursts plus single-word tails.
module sd_fill_writer
    import sd_fill_pkg::*;
#(
    parameter int BURST_WORDS = BURST_WORDS_DEF,
    parameter int LEN_W       = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  cmd_address_i,
    input  logic [7:0]  cmd_byte_i,
    input  logic        cmd_write_i,
    output logic        cmd_done_o,
    output logic        busy_o,
    output logic        fill_done_o,
    output logic [31:0] sd_address_o,
    output logic        sd_rw_req_o,
    output logic        sd_rw_o,
    output logic [15:0] sd_write_data_o,
    output logic        sd_burst_len_o,
    input  logic        sd_data_bursting_i
);
    localparam int CNT_W = $clog2(BURST_WORDS + 1);

    state_t           state_q;
    logic [31:0]      addr_q, dest;
    logic [LEN_W-1:0] rem_q, len;
    logic [15:0]      data_q, pat;
    logic [CNT_W-1:0] cnt_q;
    logic             inc_q, abort_q, busy_q, fill_done_q, req_q, blen_q;
    logic             inc, start_s, abort_s, active;

    sd_fill_regs #(.LEN_W(LEN_W)) u_regs (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cmd_address_i(cmd_address_i),
        .cmd_byte_i   (cmd_byte_i),
        .cmd_write_i  (cmd_write_i),
        .busy_i       (busy_q),
        .cmd_done_o   (cmd_done_o),
        .dest_o       (dest),
        .len_o        (len),
        .pat_o        (pat),
        .inc_o        (inc),
        .start_o      (start_s),
        .abort_o      (abort_s)
    );

    function automatic logic full_burst(input logic [LEN_W-1:0] n);
        return n >= LEN_W'(BURST_WORDS);
    endfunction

    assign active = state_q == REQ || state_q == BURST;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            inc_q       <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
            req_q       <= 1'b0;
            blen_q      <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            if (active && abort_s)
                abort_q <= 1'b1;
            // cnt_q bounds consumption to the granted burst, so overrun cycles are ignored.
            if (active && sd_data_bursting_i && cnt_q != '0) begin
                addr_q <= addr_q + 32'd2;
                rem_q  <= rem_q - LEN_W'(1);
                cnt_q  <= cnt_q - CNT_W'(1);
                data_q <= inc_q ? data_q + 16'd1 : data_q;
            end
            case (state_q)
                IDLE: if (start_s) begin
                    addr_q  <= dest & 32'hFFFF_FFFE;
                    rem_q   <= len;
                    data_q  <= pat;
                    inc_q   <= inc;
                    abort_q <= 1'b0;
                    if (len != '0) begin
                        state_q <= REQ;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        blen_q  <= full_burst(len);
                        cnt_q   <= full_burst(len) ? CNT_W'(BURST_WORDS) : CNT_W'(1);
                    end else begin
                        state_q     <= DONE;
                        fill_done_q <= 1'b1;
                    end
                end
                REQ: if (sd_data_bursting_i) begin
                    req_q   <= 1'b0;
                    state_q <= BURST;
                end
                BURST: if (!sd_data_bursting_i) begin
                    if (rem_q == '0 || abort_q) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        fill_done_q <= 1'b1;
                    end else begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        blen_q  <= full_burst(rem_q);
                        cnt_q   <= full_burst(rem_q) ? CNT_W'(BURST_WORDS) : CNT_W'(1);
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign fill_done_o     = fill_done_q;
    assign sd_address_o    = addr_q;
    assign sd_rw_req_o     = req_q;
    assign sd_rw_o         = 1'b1;
    assign sd_write_data_o = data_q;
    assign sd_burst_len_o  = blen_q;
endmodule
